ov7670_capture_rgb565: RTL and testbench
========================================

Name: ov7670_capture_rgb565

Overview:
- Pixel-capture front end for the OV7670 camera; runs entirely in the camera pclk domain.
- Samples the 8-bit DVP bus (vsync/href/data) and packs byte pairs into RGB565 words.
- Discards the first frames after sensor configuration, so register settings can settle.
- Produces the write-FIFO request/data and the frame address-load level for the downstream SDRAM FIFO controller, plus geometry-error status.

Parameters:
- H_ACTIVE, 640, pixels (16-bit words) expected per href line
- V_ACTIVE, 480, lines expected per frame
- SKIP_FRAMES, 10, complete frames discarded after init_done rises (0 = none)
- VSYNC_POL, 1, 1: vsync high marks vertical blanking; 0: vsync low marks it

Ports:
- pclk  in  1  camera pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- init_done  in  1  SCCB configuration complete; from another domain, 2-flop synchronised internally
- cmos_vsync  in  1  camera vertical sync
- cmos_href  in  1  camera line-valid
- cmos_data  in  8  camera pixel byte
- wr_en  out  1  one-cycle strobe per packed pixel (FIFO write request)
- wr_data  out  16  RGB565 pixel; valid when wr_en=1
- frame_load  out  1  high during vertical blanking once capture is enabled (address-reload level)
- frame_valid  out  1  high while the current frame is being forwarded
- frame_cnt  out  8  forwarded-frame counter, wraps 255->0
- line_err  out  1  sticky per frame; a line's pixel count differed from H_ACTIVE
- frame_err  out  1  sticky per frame; the frame's line count differed from V_ACTIVE

Behaviour:
- Reset: all outputs 0; counters 0; state SKIP; byte phase 0.
- Inputs vsync/href/data registered once (stage s1); all decisions use s1; vs_blank = (s1_vsync == VSYNC_POL).
- init_done synchronised (2 flops) and then treated as level. If it deasserts, the FSM returns to SKIP immediately and the skip count restarts.
- FSM states:
  - SKIP (init_done=0, or skip count < SKIP_FRAMES): skip_cnt increments on each vs_blank rising edge while init_done=1. Leave SKIP for WAIT_VS when skip_cnt reaches SKIP_FRAMES.
  - WAIT_VS: wait for the next vs_blank rising edge, then go to BLANK. This guarantees the first forwarded frame starts clean.
  - BLANK: frame_load=1, frame_valid=0; line/pixel counters cleared. On vs_blank falling edge go to ACTIVE.
  - ACTIVE: frame_valid=1, frame_load=0. On vs_blank rising edge:
    - frame_err <= (line_cnt != V_ACTIVE)
    - frame_cnt++
    - go to BLANK
- Sticky-flag clearing: line_err and frame_err clear on the ACTIVE entry of the next frame. frame_err is updated at the end of the frame (on the vs_blank rising edge).
- Packing (ACTIVE only, s1_href=1):
  - phase 0: latch byte as high half.
  - phase 1: wr_data <= {hi, byte}; wr_en=1 on the next clock edge (latency: 2 pclk from the second byte on pins to the wr_en cycle).
  - phase toggles per href byte and resets to 0 when href is low. A trailing odd byte is dropped.
- Line accounting:
  - pix_cnt (11 b) counts wr_en strobes; it saturates at 2047 rather than wrapping.
  - On s1_href falling edge: line_cnt (10 b, saturating) increments; line_err sets if pix_cnt != H_ACTIVE; pix_cnt clears.
- href while vs_blank: bytes ignored, no wr_en.
- vsync edge in mid-line: the partial line is counted, then the frame closes.
- wr_en never asserts outside ACTIVE. No backpressure: the downstream FIFO is sized to absorb; overflow is not detected here.
- Reset mid-frame: all state returns to reset values; capture resumes via SKIP.

Decomposition:
- Shared package: VSYNC_POL encoding, FSM state enum (SKIP, WAIT_VS, BLANK, ACTIVE), RGB565 field widths.
- One sub-module, dvp_byte_packer: s1 registers, phase toggle, 16-bit assembly, wr_en generation.
- FSM and counters stay in the top level.

Test Plan:
- init_done=1, SKIP_FRAMES=2, three 640x480 frames -> no wr_en in frames 1-2; frame 3 gives 307200 wr_en; frame_cnt=1; frame_load high in each blanking from frame 3.
- Bytes 0xF8,0x1F on one href pair -> wr_data=0xF81F with wr_en exactly 2 pclk after the second byte; single-cycle strobe.
- Line with 1281 bytes (odd) -> 640 wr_en, last byte dropped, line_err=0; line with 1278 bytes -> line_err=1 held to the next frame start, then cleared.
- Frame with 479 href lines -> frame_err=1 at the vsync edge; the following correct frame clears it on ACTIVE entry.
- init_done deasserted mid-ACTIVE -> wr_en stops within 3 pclk; frame_valid=0; after re-assert, SKIP_FRAMES frames are discarded again.
- rst_n pulsed low mid-line -> all outputs 0 asynchronously; on release the block restarts in SKIP with frame_cnt=0.

Source files
------------

// File: rtl/ov7670_capture_rgb565_pkg.sv
// Shared types and constants for the OV7670 RGB565 capture front end.
package ov7670_capture_rgb565_pkg;

    // DVP bus and RGB565 pixel geometry
    localparam int unsigned DVP_W = 8;
    localparam int unsigned R_W   = 5;
    localparam int unsigned G_W   = 6;
    localparam int unsigned B_W   = 5;
    localparam int unsigned PIX_W = R_W + G_W + B_W;

    // Counter widths
    localparam int unsigned PIX_CNT_W  = 11;
    localparam int unsigned LINE_CNT_W = 10;
    localparam int unsigned SKIP_CNT_W = 8;
    localparam int unsigned FRM_CNT_W  = 8;

    // vsync polarity encoding: level of vsync that marks vertical blanking
    localparam bit VSYNC_POL_HIGH = 1'b1;

    typedef enum logic [1:0] {
        ST_SKIP,
        ST_WAIT_VS,
        ST_BLANK,
        ST_ACTIVE
    } cap_state_t;

    function automatic logic vs_is_blank(input logic vsync, input bit pol);
        return (vsync == pol);
    endfunction

endpackage

// File: rtl/ov7670_capture_rgb565_if.sv
// Camera DVP input bus plus write-FIFO / frame-control output bus.
interface ov7670_capture_rgb565_if;
    import ov7670_capture_rgb565_pkg::*;

    logic             cmos_vsync;
    logic             cmos_href;
    logic [DVP_W-1:0] cmos_data;
    logic             wr_en;
    logic [PIX_W-1:0] wr_data;
    logic             frame_load;
    logic             frame_valid;

    // capture block side
    modport master (
        input  cmos_vsync, cmos_href, cmos_data,
        output wr_en, wr_data, frame_load, frame_valid
    );

    // camera / FIFO-controller side
    modport slave (
        output cmos_vsync, cmos_href, cmos_data,
        input  wr_en, wr_data, frame_load, frame_valid
    );

endinterface

// File: rtl/ov7670_capture_rgb565_packer.sv
// DVP input register stage and byte-pair to RGB565 packer.
module dvp_byte_packer
    import ov7670_capture_rgb565_pkg::*;
(
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             cmos_vsync,
    input  logic             cmos_href,
    input  logic [DVP_W-1:0] cmos_data,
    input  logic             pack_en,
    output logic             s1_vsync,
    output logic             s1_href,
    output logic             wr_en,
    output logic [PIX_W-1:0] wr_data
);

    logic [DVP_W-1:0] s1_data;
    logic [DVP_W-1:0] hi_byte;
    logic             phase;

    // Register the camera pins once; every decision downstream uses these.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vsync <= 1'b0;
            s1_href  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_vsync <= cmos_vsync;
            s1_href  <= cmos_href;
            s1_data  <= cmos_data;
        end
    end

    // First byte of a pair is the high half; the second completes the pixel.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            hi_byte <= '0;
            wr_en   <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (pack_en && s1_href) begin
                if (!phase) begin
                    hi_byte <= s1_data;
                    phase   <= 1'b1;
                end else begin
                    wr_data <= {hi_byte, s1_data};
                    wr_en   <= 1'b1;
                    phase   <= 1'b0;
                end
            end else begin
                // href low (or not capturing): drop any unpaired byte
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ov7670_capture_rgb565.sv
// OV7670 capture front end: frame skipping, frame FSM, line/frame geometry check.
module ov7670_capture_rgb565
    import ov7670_capture_rgb565_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SKIP_FRAMES = 10,
    parameter bit          VSYNC_POL   = VSYNC_POL_HIGH
)
(
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic                       init_done,
    ov7670_capture_rgb565_if.master    bus,
    output logic [FRM_CNT_W-1:0]       frame_cnt,
    output logic                       line_err,
    output logic                       frame_err
);

    localparam logic [PIX_CNT_W-1:0]  H_TGT    = PIX_CNT_W'(H_ACTIVE);
    localparam logic [LINE_CNT_W-1:0] V_TGT    = LINE_CNT_W'(V_ACTIVE);
    localparam logic [SKIP_CNT_W-1:0] SKIP_TGT = SKIP_CNT_W'(SKIP_FRAMES);

    cap_state_t             state, state_nxt;
    logic                   init_s0, init_s1;
    logic                   s1_vsync, s1_href, href_d;
    logic                   vs_blank, vs_blank_d, vs_rise, vs_fall;
    logic                   in_active, pack_en, line_end;
    logic                   pk_wr_en, wr_strobe;
    logic [PIX_W-1:0]       pk_wr_data;
    logic [SKIP_CNT_W-1:0]  skip_cnt;
    logic [PIX_CNT_W-1:0]   pix_cnt, pix_nxt;
    logic [LINE_CNT_W-1:0]  line_cnt, line_nxt;

    dvp_byte_packer u_packer (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .cmos_vsync (bus.cmos_vsync),
        .cmos_href  (bus.cmos_href),
        .cmos_data  (bus.cmos_data),
        .pack_en    (pack_en),
        .s1_vsync   (s1_vsync),
        .s1_href    (s1_href),
        .wr_en      (pk_wr_en),
        .wr_data    (pk_wr_data)
    );

    // Synchronise init_done and keep one-cycle history for edge detection.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            init_s0    <= 1'b0;
            init_s1    <= 1'b0;
            vs_blank_d <= 1'b1;   // treat reset as blanking: no false rise
            href_d     <= 1'b0;
        end else begin
            init_s0    <= init_done;
            init_s1    <= init_s0;
            vs_blank_d <= vs_blank;
            href_d     <= s1_href;
        end
    end

    // Edge events, write gating and next-count values.
    // The last pixel's strobe lands in the same cycle href is seen falling,
    // so the line check uses pix_nxt (count including this cycle's strobe).
    always_comb begin
        vs_blank  = vs_is_blank(s1_vsync, VSYNC_POL);
        vs_rise   = vs_blank & ~vs_blank_d;
        vs_fall   = ~vs_blank & vs_blank_d;
        in_active = (state == ST_ACTIVE);
        pack_en   = in_active & ~vs_blank;
        wr_strobe = pk_wr_en & in_active;
        line_end  = in_active & href_d & (~s1_href | vs_rise);
        pix_nxt   = (pix_cnt == '1) ? pix_cnt : pix_cnt + PIX_CNT_W'(wr_strobe);
        line_nxt  = (line_end && line_cnt != '1) ? line_cnt + LINE_CNT_W'(1) : line_cnt;
        bus.wr_en   = wr_strobe;
        bus.wr_data = pk_wr_data;
    end

    // FSM state register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SKIP;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and frame-level outputs.
    always_comb begin
        state_nxt       = state;
        bus.frame_load  = 1'b0;
        bus.frame_valid = 1'b0;
        if (!init_s1) begin
            state_nxt = ST_SKIP;
        end else begin
            unique case (state)
                ST_SKIP:    if (skip_cnt == SKIP_TGT) state_nxt = ST_WAIT_VS;
                ST_WAIT_VS: if (vs_rise)              state_nxt = ST_BLANK;
                ST_BLANK:   if (vs_fall)              state_nxt = ST_ACTIVE;
                ST_ACTIVE:  if (vs_rise)              state_nxt = ST_BLANK;
                default:                              state_nxt = ST_SKIP;
            endcase
        end
        case (state)
            ST_BLANK:  bus.frame_load  = 1'b1;
            ST_ACTIVE: bus.frame_valid = 1'b1;
            default: ;
        endcase
    end

    // Skip counting, pixel/line accounting and sticky geometry flags.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt  <= '0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            frame_cnt <= '0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state == ST_SKIP && init_s1) begin
                if (vs_rise && skip_cnt != SKIP_TGT) begin
                    skip_cnt <= skip_cnt + SKIP_CNT_W'(1);
                end
            end else begin
                skip_cnt <= '0;
            end

            if (state == ST_ACTIVE && init_s1) begin
                pix_cnt  <= line_end ? '0 : pix_nxt;
                line_cnt <= line_nxt;
                if (line_end && pix_nxt != H_TGT) begin
                    line_err <= 1'b1;
                end
                if (vs_rise) begin
                    frame_err <= (line_nxt != V_TGT);
                    frame_cnt <= frame_cnt + FRM_CNT_W'(1);
                end
            end else begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                if (state == ST_BLANK && state_nxt == ST_ACTIVE) begin
                    line_err  <= 1'b0;
                    frame_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture_rgb565.sv
// Scoreboard bench for ov7670_capture_rgb565 with small frame geometry.
module tb_ov7670_capture_rgb565;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 4;
    localparam int unsigned SKIP = 2;
    localparam int          LB   = 2 * H;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_done = 1'b0;
    logic [7:0] frame_cnt;
    logic       line_err;
    logic       frame_err;

    ov7670_capture_rgb565_if bus();

    ov7670_capture_rgb565 #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SKIP_FRAMES (SKIP),
        .VSYNC_POL   (1'b1)
    ) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .line_err  (line_err),
        .frame_err (frame_err)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [15:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // reference model state
    int fidx = 0;
    int lines_sent = 0;
    int exp_cnt = 0;
    bit prev_fwd = 0;
    bit cur_fwd = 0;
    bit exp_lerr = 0;
    bit exp_ferr = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest expected pixel and its cycle.
    always @(negedge pclk) begin
        if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_wr_en: got strobe data %h at cycle %0d, expected none", bus.wr_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_data", bus.wr_data, e.data);
                check("wr_cycle", cyc, e.cyc);
                check("frame_valid_on_wr", bus.frame_valid, 1);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Vertical blanking that closes the previous frame and opens the next.
    task automatic frame_begin();
        bit fwd;
        fwd = (fidx >= SKIP);
        if (prev_fwd) begin
            exp_ferr = (lines_sent != V);
            exp_cnt  = (exp_cnt + 1) % 256;
        end
        bus.cmos_vsync = 1'b1;
        tick(4);
        check("frame_load_blank", bus.frame_load, fwd);
        check("frame_valid_blank", bus.frame_valid, 0);
        check("frame_cnt", frame_cnt, exp_cnt);
        check("frame_err_end", frame_err, exp_ferr);
        check("line_err_held", line_err, exp_lerr);
        bus.cmos_vsync = 1'b0;
        tick(3);
        if (fwd) begin
            exp_ferr = 0;
            exp_lerr = 0;
        end
        check("frame_valid_active", bus.frame_valid, fwd);
        check("frame_load_active", bus.frame_load, 0);
        check("line_err_start", line_err, exp_lerr);
        check("frame_err_start", frame_err, exp_ferr);
        lines_sent = 0;
        prev_fwd   = fwd;
        cur_fwd    = fwd;
        fidx++;
    endtask

    // One href line of nbytes random bytes; pixel k = {byte 2k, byte 2k+1}.
    task automatic send_line(input int nbytes, input bit fixed);
        logic [7:0] b;
        logic [7:0] hi;
        hi = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom);
            if (fixed && i == 0) b = 8'hF8;
            if (fixed && i == 1) b = 8'h1F;
            bus.cmos_href = 1'b1;
            bus.cmos_data = b;
            if (i % 2 == 1) begin
                if (cur_fwd) sb.push_back('{data: {hi, b}, cyc: cyc + 2});
            end else begin
                hi = b;
            end
            tick();
        end
        bus.cmos_href = 1'b0;
        bus.cmos_data = 8'($urandom);
        if (cur_fwd) begin
            lines_sent++;
            if (nbytes / 2 != H) exp_lerr = 1;
        end
        tick(4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_frame_load"}, bus.frame_load, 0);
        check({tag, "_frame_valid"}, bus.frame_valid, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_line_err"}, line_err, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] hi;
        bus.cmos_vsync = 1'b0;
        bus.cmos_href  = 1'b0;
        bus.cmos_data  = 8'h00;
        hi = 8'h00;
        tick(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);
        init_done = 1'b1;
        tick(6);

        // frames 0,1 discarded; frame 2 forwarded and starts with 0xF8,0x1F
        repeat (2) begin frame_begin(); repeat (V) send_line(LB, 0); end
        frame_begin(); send_line(LB, 1); repeat (V - 1) send_line(LB, 0);
        // odd-length line: trailing byte dropped, no line error
        frame_begin(); send_line(LB + 1, 0); repeat (V - 1) send_line(LB, 0);
        // short line: line_err until next ACTIVE entry
        frame_begin(); send_line(LB, 0); send_line(LB - 2, 0); repeat (V - 2) send_line(LB, 0);
        // one line missing: frame_err
        frame_begin(); repeat (V - 1) send_line(LB, 0);
        // clean frame clears both flags
        frame_begin(); repeat (V) send_line(LB, 0);

        // init_done drops between lines of a forwarded frame
        frame_begin(); send_line(LB, 0); send_line(LB, 0);
        init_done = 1'b0;
        tick(6);
        check("frame_valid_init_drop", bus.frame_valid, 0);
        check("frame_load_init_drop", bus.frame_load, 0);
        cur_fwd  = 0;
        prev_fwd = 0;
        send_line(LB, 0); send_line(LB, 0);
        init_done = 1'b1;
        fidx = 0;
        tick(4);
        repeat (3) begin frame_begin(); repeat (V) send_line(LB, 0); end

        // reset pulsed in the middle of a forwarded line
        frame_begin(); send_line(LB, 0);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            bus.cmos_href = 1'b1;
            bus.cmos_data = b;
            if (i % 2 == 1) sb.push_back('{data: {hi, b}, cyc: cyc + 2});
            else hi = b;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        sb.delete();
        bus.cmos_href = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        check("frame_cnt_after_reset", frame_cnt, 0);
        check("frame_valid_after_reset", bus.frame_valid, 0);
        fidx = 0; exp_cnt = 0; exp_ferr = 0; exp_lerr = 0; prev_fwd = 0; cur_fwd = 0;
        repeat (3) begin frame_begin(); repeat (V) send_line(LB, 0); end
        frame_begin();
        tick(10);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
